// File: rtl/act_unit_arbiter.sv
// act_unit_arbiter: shares one serial hard-swish / hard-sigmoid activation unit
// between the expansion-path hswish stream (ch0) and the SE-excitation hsigmoid
// stream (ch1). Requests are granted round-robin and issued one per cycle. Each
// issued sample leaves its channel id in a tag FIFO. Each unit result pops the
// head tag and is routed back to the channel that issued it.
//
// Handshake: a request transfers in any cycle where reqN_valid && reqN_ready.
// reqN_ready is combinational and is never high while reqN_valid is low. Once
// raised, a valid stays high with stable data until the transfer completes.
// The act_* and rsp* sides have no backpressure: a valid is consumed in the
// cycle it is high.
module act_unit_arbiter #(
    parameter int DATA_WIDTH  = 16,
    parameter int ACT_LATENCY = 1,
    parameter int TAG_DEPTH   = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           req0_valid,
    input  logic [DATA_WIDTH-1:0]          req0_data,
    output logic                           req0_ready,
    input  logic                           req1_valid,
    input  logic [DATA_WIDTH-1:0]          req1_data,
    output logic                           req1_ready,
    output logic                           act_in_valid,
    output logic [DATA_WIDTH-1:0]          act_in_data,
    input  logic                           act_out_valid,
    input  logic [DATA_WIDTH-1:0]          act_hsig,
    input  logic [DATA_WIDTH-1:0]          act_hswish,
    output logic                           rsp0_valid,
    output logic                           rsp1_valid,
    output logic [DATA_WIDTH-1:0]          rsp_hsig,
    output logic [DATA_WIDTH-1:0]          rsp_hswish,
    output logic [$clog2(TAG_DEPTH+1)-1:0] inflight,
    output logic                           err_orphan
);

    localparam int CW = $clog2(TAG_DEPTH + 1);
    localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;

    // Without at least ACT_LATENCY+1 tag entries the pipe cannot stay full.
    if (TAG_DEPTH < ACT_LATENCY + 1) begin : g_depth_check
        $error("act_unit_arbiter: TAG_DEPTH must be >= ACT_LATENCY+1");
    end

    // Tag FIFO: one bit per entry, 0 = ch0, 1 = ch1.
    logic [TAG_DEPTH-1:0] tag_mem;
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [CW-1:0]        count;
    logic [CW-1:0]        count_next;
    logic                 last_grant;

    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  pop_ok;
    logic                  can_issue;
    logic                  grant0;
    logic                  grant1;
    logic                  push;
    logic                  push_tag;
    logic                  pop;
    logic                  pop_tag;
    logic                  orphan;
    logic [DATA_WIDTH-1:0] issue_data;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(TAG_DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // Round-robin grant, FIFO push/pop decisions and the next occupancy.
    always_comb begin
        fifo_empty = (count == '0);
        fifo_full  = (count == CW'(TAG_DEPTH));
        pop_ok     = act_out_valid && !fifo_empty;
        // A pop in the same cycle frees the slot the push needs.
        can_issue  = !rst && (!fifo_full || pop_ok);
        // last_grant == 1 means ch1 went last, so ch0 has priority on a tie.
        grant0     = can_issue && req0_valid && (!req1_valid || last_grant);
        grant1     = can_issue && req1_valid && (!req0_valid || !last_grant);
        push       = grant0 || grant1;
        push_tag   = grant1;
        issue_data = grant1 ? req1_data : req0_data;
        // With an empty FIFO a result can only belong to a tag pushed this
        // same cycle; otherwise it is an orphan and is dropped.
        pop        = act_out_valid && (!fifo_empty || push);
        pop_tag    = fifo_empty ? push_tag : tag_mem[rd_ptr];
        orphan     = act_out_valid && fifo_empty && !push;
        count_next = count;
        if (push && !pop) begin
            count_next = count + 1'b1;
        end else if (pop && !push) begin
            count_next = count - 1'b1;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign inflight   = count;

    // Tag FIFO, arbitration history, issue register and response register.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_mem      <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            last_grant   <= 1'b1;
            act_in_valid <= 1'b0;
            act_in_data  <= '0;
            rsp0_valid   <= 1'b0;
            rsp1_valid   <= 1'b0;
            rsp_hsig     <= '0;
            rsp_hswish   <= '0;
            err_orphan   <= 1'b0;
        end else begin
            if (push) begin
                tag_mem[wr_ptr] <= push_tag;
                wr_ptr          <= ptr_inc(wr_ptr);
                last_grant      <= push_tag;
                act_in_data     <= issue_data;
            end
            if (pop) begin
                rd_ptr     <= ptr_inc(rd_ptr);
                rsp_hsig   <= act_hsig;
                rsp_hswish <= act_hswish;
            end
            count        <= count_next;
            act_in_valid <= push;
            rsp0_valid   <= pop && !pop_tag;
            rsp1_valid   <= pop && pop_tag;
            if (orphan) begin
                err_orphan <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_act_unit_arbiter.sv
// Directed bench for act_unit_arbiter. A stub activation unit with selectable
// latency returns hsig = in and hswish = ~in.
module tb_act_unit_arbiter;

    localparam int DW = 16;
    localparam int TD = 4;
    localparam int CW = $clog2(TD + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0_valid = 1'b0;
    logic [DW-1:0] req0_data = '0;
    logic          req0_ready;
    logic          req1_valid = 1'b0;
    logic [DW-1:0] req1_data = '0;
    logic          req1_ready;
    logic          act_in_valid;
    logic [DW-1:0] act_in_data;
    logic          act_out_valid;
    logic [DW-1:0] act_hsig;
    logic [DW-1:0] act_hswish;
    logic          rsp0_valid;
    logic          rsp1_valid;
    logic [DW-1:0] rsp_hsig;
    logic [DW-1:0] rsp_hswish;
    logic [CW-1:0] inflight;
    logic          err_orphan;

    int   n_chk = 0;
    int   n_fail = 0;
    int   stub_lat = 1;
    logic inject = 1'b0;

    logic [DW:0] dly [0:7];
    logic [DW:0] stub_out;

    act_unit_arbiter #(.DATA_WIDTH(DW), .ACT_LATENCY(1), .TAG_DEPTH(TD)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .act_in_valid(act_in_valid), .act_in_data(act_in_data),
        .act_out_valid(act_out_valid), .act_hsig(act_hsig), .act_hswish(act_hswish),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
        .rsp_hsig(rsp_hsig), .rsp_hswish(rsp_hswish),
        .inflight(inflight), .err_orphan(err_orphan)
    );

    // Clock generation.
    always #5 clk = ~clk;

    // Stub unit: delay line tapped at stub_lat stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 8; k++) dly[k] <= '0;
        end else begin
            dly[0] <= {act_in_valid, act_in_data};
            for (int k = 1; k < 8; k++) dly[k] <= dly[k-1];
        end
    end

    // Stub outputs plus a forced valid for orphan injection.
    always_comb begin
        stub_out      = dly[stub_lat-1];
        act_out_valid = stub_out[DW] | inject;
        act_hsig      = stub_out[DW-1:0];
        act_hswish    = ~stub_out[DW-1:0];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        inject = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [15:0] t1_d [4] = '{16'hFFFD, 16'h0000, 16'h0003, 16'h0006};
    logic [15:0] t1_s [4] = '{16'h0002, 16'hFFFF, 16'hFFFC, 16'hFFF9};
    int          t1_inf [10] = '{0, 1, 2, 2, 2, 1, 0, 0, 0, 0};
    logic [15:0] t3_rdy = 16'hC78F;
    logic [15:0] e;
    logic [15:0] ex;
    int          k0, k1, n0, n1, max_inf;

    initial begin
        // Reset state
        do_reset();
        #1;
        chk("rst_act_in_valid", act_in_valid, 0);
        chk("rst_act_in_data", act_in_data, 0);
        chk("rst_req0_ready", req0_ready, 0);
        chk("rst_req1_ready", req1_ready, 0);
        chk("rst_rsp0_valid", rsp0_valid, 0);
        chk("rst_rsp1_valid", rsp1_valid, 0);
        chk("rst_rsp_hsig", rsp_hsig, 0);
        chk("rst_rsp_hswish", rsp_hswish, 0);
        chk("rst_inflight", inflight, 0);
        chk("rst_err_orphan", err_orphan, 0);
        @(negedge clk);

        // 1: ch0 alone sends -3,0,3,6 back-to-back
        for (int c = 0; c < 10; c++) begin
            req0_valid = (c < 4);
            if (c < 4) req0_data = t1_d[c];
            else req0_data = 16'h0000;
            #1;
            chk("t1_ready0", req0_ready, (c < 4));
            chk("t1_ready1", req1_ready, 0);
            chk("t1_act_in_valid", act_in_valid, (c >= 1 && c <= 4));
            if (c >= 1 && c <= 4) chk("t1_act_in_data", act_in_data, t1_d[c-1]);
            chk("t1_rsp0", rsp0_valid, (c >= 3 && c <= 6));
            chk("t1_rsp1", rsp1_valid, 0);
            if (c >= 3 && c <= 6) begin
                chk("t1_hsig", rsp_hsig, t1_d[c-3]);
                chk("t1_hswish", rsp_hswish, t1_s[c-3]);
            end
            chk("t1_inflight", inflight, t1_inf[c]);
            @(negedge clk);
        end

        // 2: both channels valid for 8 cycles, alternating grants
        do_reset();
        n0 = 0; n1 = 0; k0 = 0; k1 = 0;
        for (int c = 0; c < 13; c++) begin
            req0_valid = (c < 8);
            req1_valid = (c < 8);
            req0_data  = 16'h0100 + 16'(n0);
            req1_data  = 16'h0200 + 16'(n1);
            #1;
            chk("t2_ready0", req0_ready, (c < 8) && (c % 2 == 0));
            chk("t2_ready1", req1_ready, (c < 8) && (c % 2 == 1));
            if (req0_ready) n0++;
            if (req1_ready) n1++;
            chk("t2_rsp0", rsp0_valid, (c >= 3) && (c <= 9) && (c % 2 == 1));
            chk("t2_rsp1", rsp1_valid, (c >= 4) && (c <= 10) && (c % 2 == 0));
            if (rsp0_valid) begin
                e = 16'h0100 + 16'(k0); ex = ~e;
                chk("t2_rsp0_hsig", rsp_hsig, e);
                chk("t2_rsp0_hswish", rsp_hswish, ex);
                k0++;
            end
            if (rsp1_valid) begin
                e = 16'h0200 + 16'(k1); ex = ~e;
                chk("t2_rsp1_hsig", rsp_hsig, e);
                chk("t2_rsp1_hswish", rsp_hswish, ex);
                k1++;
            end
            @(negedge clk);
        end
        chk("t2_rsp0_count", k0, 4);
        chk("t2_rsp1_count", k1, 4);
        chk("t2_inflight_end", inflight, 0);

        // 6: ch1 valid only on odd cycles, ch0 always valid
        n0 = 0; n1 = 0; k0 = 0; k1 = 0;
        for (int c = 0; c < 12; c++) begin
            req0_valid = (c < 8);
            req1_valid = (c < 8) && (c % 2 == 1);
            req0_data  = 16'h0400 + 16'(n0);
            req1_data  = 16'h0500 + 16'(n1);
            #1;
            chk("t6_ready0", req0_ready, (c < 8) && (c % 2 == 0));
            chk("t6_ready1", req1_ready, (c < 8) && (c % 2 == 1));
            if (req0_ready) n0++;
            if (req1_ready) n1++;
            if (rsp0_valid) begin
                e = 16'h0400 + 16'(k0);
                chk("t6_rsp0_hsig", rsp_hsig, e);
                k0++;
            end
            if (rsp1_valid) begin
                e = 16'h0500 + 16'(k1);
                chk("t6_rsp1_hsig", rsp_hsig, e);
                k1++;
            end
            @(negedge clk);
        end
        chk("t6_rsp0_count", k0, 4);
        chk("t6_rsp1_count", k1, 4);

        // 3: stub latency 6, continuous ch0, FIFO saturates at 4
        stub_lat = 6;
        do_reset();
        n0 = 0; k0 = 0; max_inf = 0;
        for (int c = 0; c < 56; c++) begin
            req0_valid = (c < 16);
            req0_data  = 16'h0300 + 16'(n0);
            #1;
            if (c < 16) chk("t3_ready0", req0_ready, t3_rdy[c]);
            if (c == 5) chk("t3_inflight_full", inflight, 4);
            if (int'(inflight) > max_inf) max_inf = int'(inflight);
            if (req0_ready) n0++;
            chk("t3_rsp1", rsp1_valid, 0);
            if (rsp0_valid) begin
                e = 16'h0300 + 16'(k0);
                chk("t3_rsp0_hsig", rsp_hsig, e);
                k0++;
            end
            @(negedge clk);
        end
        chk("t3_accepted", n0, 10);
        chk("t3_returned", k0, 10);
        chk("t3_max_inflight", max_inf, 4);
        chk("t3_inflight_end", inflight, 0);

        // 4: orphan result with empty FIFO
        inject = 1'b1;
        #1;
        chk("t4_err_before", err_orphan, 0);
        chk("t4_inflight_before", inflight, 0);
        @(negedge clk);
        inject = 1'b0;
        #1;
        chk("t4_err_set", err_orphan, 1);
        chk("t4_rsp0", rsp0_valid, 0);
        chk("t4_rsp1", rsp1_valid, 0);
        chk("t4_inflight", inflight, 0);
        repeat (5) @(negedge clk);
        #1;
        chk("t4_err_hold", err_orphan, 1);
        @(negedge clk);

        // 5: reset with 3 samples in flight
        for (int c = 0; c < 3; c++) begin
            req0_valid = 1'b1;
            req0_data  = 16'h0600 + 16'(c);
            #1;
            chk("t5_ready0", req0_ready, 1);
            @(negedge clk);
        end
        req0_valid = 1'b0;
        #1;
        chk("t5_inflight_pre", inflight, 3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t5_inflight", inflight, 0);
        chk("t5_act_in_valid", act_in_valid, 0);
        chk("t5_act_in_data", act_in_data, 0);
        chk("t5_rsp0", rsp0_valid, 0);
        chk("t5_rsp1", rsp1_valid, 0);
        chk("t5_rsp_hsig", rsp_hsig, 0);
        chk("t5_rsp_hswish", rsp_hswish, 0);
        chk("t5_err_orphan", err_orphan, 0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            chk("t5_stale_rsp0", rsp0_valid, 0);
            chk("t5_stale_rsp1", rsp1_valid, 0);
            chk("t5_stale_inflight", inflight, 0);
        end
        @(negedge clk);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_data  = 16'h0700;
        req1_data  = 16'h0800;
        #1;
        chk("t5_first_ready0", req0_ready, 1);
        chk("t5_first_ready1", req1_ready, 0);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        chk("t5_issue_valid", act_in_valid, 1);
        chk("t5_issue_data", act_in_data, 16'h0700);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
